// File: rtl/scs8hd_sipo4_2_if.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_sipo4_2_if
// Purpose  : Bundle of the serial input, handshake and parallel output signals
//            of the 4-bit serial-in/parallel-out deserializer cell.
//            The perr signal exists only when SCS8HD_SIPO_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface scs8hd_sipo4_2_if;
  logic       din;
  logic       den;
  logic       fs;
  logic       ack;
  logic [3:0] q;
  logic       valid;
  logic       ovr;
`ifdef SCS8HD_SIPO_PARITY_EN
  logic       perr;
`endif

  // Producer of the serial stream and consumer of the parallel word
  modport master (
    output din, den, fs, ack,
`ifdef SCS8HD_SIPO_PARITY_EN
    input  perr,
`endif
    input  q, valid, ovr
  );

  // The deserializer cell itself
  modport slave (
    input  din, den, fs, ack,
`ifdef SCS8HD_SIPO_PARITY_EN
    output perr,
`endif
    output q, valid, ovr
  );
endinterface
`default_nettype wire

// File: rtl/scs8hd_sipo4_2.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_sipo4_2
// Purpose  : Clocked 4-bit serial-in/parallel-out deserializer. Collects four
//            framed serial bits (FS marks bit 0, DEN qualifies each bit) and
//            presents the word with a VALID/ACK handshake and a sticky overrun
//            flag. Optional even-parity bit via macro SCS8HD_SIPO_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module scs8hd_sipo4_2 #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  scs8hd_sipo4_2_if.slave   bus
);

`ifdef SCS8HD_SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
  // All four data bits must be held while waiting for the parity bit
  localparam int SHW = 4;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
  // The 4th bit is taken straight from din on the completing edge
  localparam int SHW = 3;
`endif

  state_t           state;
  logic [1:0]       cnt;
  logic [SHW-1:0]   shreg;   // shreg[k] = data bit k in arrival order
  logic [3:0]       word;    // complete data word in arrival order
  logic [3:0]       placed;  // word reordered to the Q bit placement

  // Assemble the complete word as it stands on the completing edge
  always_comb begin
`ifdef SCS8HD_SIPO_PARITY_EN
    word = shreg;
`else
    word = {bus.din, shreg};
`endif
  end

  // Map arrival order onto Q: bit k to Q[k], or to Q[3-k] when MSB first
  always_comb begin
    placed = LSB_FIRST ? word : {word[0], word[1], word[2], word[3]};
  end

  // Framing FSM with registered handshake, word and flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      shreg     <= '0;
      bus.q     <= 4'h0;
      bus.valid <= 1'b0;
      bus.ovr   <= 1'b0;
`ifdef SCS8HD_SIPO_PARITY_EN
      bus.perr  <= 1'b0;
`endif
    end else begin
      // An accepting ACK clears VALID; a word loading on this edge overrides
      if (bus.valid && bus.ack) begin
        bus.valid <= 1'b0;
      end
      if (bus.den) begin
        if (bus.fs) begin
          // Frame start resynchronises from any state, dropping partial data
          shreg <= {{(SHW-1){1'b0}}, bus.din};
          cnt   <= 2'd1;
          state <= SHIFT;
        end else begin
          case (state)
            SHIFT: begin
              if (cnt == 2'd3) begin
`ifdef SCS8HD_SIPO_PARITY_EN
                shreg[3] <= bus.din;
                cnt      <= 2'd0;
                state    <= PAR;
`else
                bus.q     <= placed;
                bus.valid <= 1'b1;
                // Unacknowledged word is being overwritten
                if (bus.valid && !bus.ack) begin
                  bus.ovr <= 1'b1;
                end
                cnt   <= 2'd0;
                state <= IDLE;
`endif
              end else begin
                shreg[cnt] <= bus.din;
                cnt        <= cnt + 2'd1;
              end
            end
`ifdef SCS8HD_SIPO_PARITY_EN
            PAR: begin
              bus.q     <= placed;
              bus.valid <= 1'b1;
              // Even parity: data bits XOR parity bit must be zero
              bus.perr  <= (^word) ^ bus.din;
              if (bus.valid && !bus.ack) begin
                bus.ovr <= 1'b1;
              end
              state <= IDLE;
            end
`endif
            default: begin
              // IDLE without frame start: bit is ignored
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/scs8hd_sipo4_2.md
# scs8hd_sipo4_2

Clocked 4-bit serial-in/parallel-out deserializer cell: the receiving end of a 4-bit-to-1 combining path. It collects four framed serial bits into a parallel word and presents the word with a VALID/ACK handshake. It sits in the scs8hd library alongside the combinational gates, for small control-bus and scan-style links where a 4-bit field arrives one bit per qualified clock.

## Interface
- LSB_FIRST, 1, 1: first received data bit lands in Q[0]; 0: first bit lands in Q[3]
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- DIN  input  1  serial data, sampled only when DEN=1
- DEN  input  1  bit qualifier; one bit consumed per edge with DEN=1
- FS  input  1  frame start; with DEN=1 marks DIN as data bit 0
- ACK  input  1  consumer acknowledge; meaningful only while VALID=1
- Q  output  4  received parallel word
- VALID  output  1  Q holds an unacknowledged word
- OVR  output  1  sticky overrun flag
- PERR  output  1  parity error of the word in Q (present only with SCS8HD_SIPO_PARITY_EN)

## Operation
- States: IDLE, SHIFT (bit counter 1..3), PAR (parity build only).
- Reset (asynchronous assert, applies immediately): state IDLE, counter 0, shift register 0, Q=4'h0, VALID=0, OVR=0, PERR=0. Reset asserted mid-frame discards the partial frame; no VALID results.
- Any state, DEN=1 and FS=1: DIN stored as bit 0, counter=1, go to SHIFT. Any partial frame in progress is discarded silently (resync).
- IDLE, DEN=1 and FS=0: bit ignored, no state change.
- SHIFT, DEN=1 and FS=0: store DIN at the next bit position and increment the counter.
- When the 4th data bit is sampled and parity is not built: assemble the word, load Q, set VALID, return to IDLE.
- DEN=0: no state, counter, or shift change. DIN and FS are ignored.
- Bit placement: with LSB_FIRST=1, bit k goes to Q[k]. With LSB_FIRST=0, bit k goes to Q[3-k].
- Handshake:
  - VALID holds until an edge with ACK=1 and VALID=1, then clears.
  - ACK while VALID=0 is ignored.
  - Q holds its value after ACK.
- Word completes while VALID=1 and ACK=0 on the same edge: Q is overwritten, VALID stays 1, OVR sets.
- Word completes on the same edge as an accepting ACK: the old word is consumed, the new word loads, VALID stays 1, OVR unchanged.
- OVR clears only on RESET.

## Timing
- All state, Q, VALID, OVR and PERR are registered on the CLK rising edge. There is no combinational input-to-output path.
- Latency: Q and VALID update on the same edge that samples the final bit (4th data bit, or the parity bit). They are visible after that edge.
- Minimum frame: 4 consecutive DEN edges (5 with parity). Back-to-back frames are allowed. FS may follow the final bit immediately.
- VALID falls on the edge that samples ACK=1.

## Configuration
- SCS8HD_SIPO_PARITY_EN defined:
  - After the 4th data bit, the state goes to PAR instead of completing.
  - The next DEN=1, FS=0 bit is the parity bit. Even parity is required: XOR of the 4 data bits and the parity bit equals 0.
  - At the parity edge: Q loads, VALID sets, and PERR is set to 1 on mismatch or 0 otherwise.
  - PERR updates with every word load and resets to 0.
  - FS=1 in PAR resyncs as described under Operation.
- SCS8HD_SIPO_PARITY_EN undefined: no PAR state and no PERR port. A frame is 4 bits.

## Test plan
- LSB_FIRST=1, bits 1,0,1,1 with FS on the first bit -> Q=4'b1101, VALID=1 after the 4th edge; ACK=1 for one cycle -> VALID=0, Q=4'b1101 held.
- LSB_FIRST=0, same bits -> Q=4'b1011. DEN=0 gaps inserted between bits -> identical result, with VALID delayed by the gap count.
- Send 2 bits, then FS with new bits 0,0,0,1 -> Q=4'b1000 (LSB_FIRST=1), exactly one VALID, OVR=0.
- Two frames with no ACK -> Q holds the second word, VALID=1, OVR=1. Repeat with ACK on the completion edge of the second frame -> VALID=1, OVR=0.
- RESET asserted after 3 bits, mid-cycle -> Q=0, VALID=0, OVR=0 immediately. Next full frame is received correctly.
- With SCS8HD_SIPO_PARITY_EN: data 1,1,0,0 with parity 0 -> PERR=0. Data 1,1,0,0 with parity 1 -> PERR=1 and Q=4'b0011.
